// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder leaf and the datapaths that consume it.
// The result bundle is sized for the widest legal adder so one type fits every instance.
package adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 4;
  localparam int ADDER_WIDTH_MAX     = 64;

  typedef struct packed {
    logic [ADDER_WIDTH_MAX-1:0] sum;
    logic                       cout;
    logic                       overflow;
  } adder_result_t;

  // Zero-extends a narrow sum into the common result bundle.
  function automatic adder_result_t pack_result(
    input logic [ADDER_WIDTH_MAX-1:0] sum,
    input logic                       cout,
    input logic                       overflow
  );
    adder_result_t r;
    r.sum      = sum;
    r.cout     = cout;
    r.overflow = overflow;
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell; the ripple adder chains WIDTH of these.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder_structural.sv
// WIDTH-bit structural ripple-carry adder with a single registered output stage.
// sum/cout/overflow hold while idle; out_valid pulses one cycle after each accepted input.
module ripple_carry_adder_structural
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH-1:0] s_comb;
  logic             cout_comb;
  logic             carry_into_msb;
  logic             overflow_comb;

  // Each cell owns its carry-in/carry-out so the ripple chain is a plain
  // cell-to-cell path rather than a self-referencing carry vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic ci;
    logic co;

    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_rest
      assign ci = g_cell[i-1].co;
    end

    full_adder u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (ci),
      .s  (s_comb[i]),
      .co (co)
    );
  end

  assign cout_comb      = g_cell[WIDTH-1].co;
  assign carry_into_msb = g_cell[WIDTH-1].ci;
  assign overflow_comb  = cout_comb ^ carry_into_msb;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             overflow_d, overflow_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = s_comb;
      cout_d      = cout_comb;
      overflow_d  = overflow_comb;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_carry_adder_structural.sv
// Scoreboard bench for the ripple-carry adder at WIDTH = 4 and WIDTH = 16.
module tb_ripple_carry_adder_structural;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v4, c4, co4, ov4, ovld4;
  logic [3:0]  a4, b4, s4;
  logic        v16, c16, co16, ov16, ovld16;
  logic [15:0] a16, b16, s16;

  ripple_carry_adder_structural #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .sum(s4), .cout(co4), .overflow(ov4), .out_valid(ovld4)
  );

  ripple_carry_adder_structural #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
    .sum(s16), .cout(co16), .overflow(ov16), .out_valid(ovld16)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q4[$];
  exp_t q16[$];
  exp_t e4, e16;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: sample 1 time unit after the edge; a queued expectation must appear exactly now.
  initial forever begin
    @(posedge clk); #1;
    check("w4_out_valid", 64'(ovld4), 64'(q4.size() > 0));
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      check("w4_sum", 64'(s4), 64'(e4.sum[3:0]));
      check("w4_cout", 64'(co4), 64'(e4.cout));
      check("w4_overflow", 64'(ov4), 64'(e4.ovf));
    end
  end

  initial forever begin
    @(posedge clk); #1;
    check("w16_out_valid", 64'(ovld16), 64'(q16.size() > 0));
    if (q16.size() > 0) begin
      e16 = q16.pop_front();
      check("w16_sum", 64'(s16), 64'(e16.sum));
      check("w16_cout", 64'(co16), 64'(e16.cout));
      check("w16_overflow", 64'(ov16), 64'(e16.ovf));
    end
  end

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic [3:0] es, input logic eco, input logic eov);
    exp_t e;
    @(negedge clk);
    v4 = 1'b1; a4 = a; b4 = b; c4 = ci;
    e.sum = {12'h000, es}; e.cout = eco; e.ovf = eov;
    q4.push_back(e);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    exp_t e;
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
    @(negedge clk);
    v16 = 1'b1; a16 = a; b16 = b; c16 = ci;
    e.sum = t[15:0]; e.cout = t[16];
    e.ovf = (a[15] == b[15]) && (t[15] != a[15]);
    q16.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] t4;
    logic [3:0] ea, eb;
    logic       ec;

    rst = 1'b1;
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;

    repeat (2) begin
      @(posedge clk); #1;
      check("rst_sum", 64'(s4), 64'h0);
      check("rst_cout", 64'(co4), 64'h0);
      check("rst_overflow", 64'(ov4), 64'h0);
      check("rst_out_valid", 64'(ovld4), 64'h0);
    end
    @(negedge clk);
    rst = 1'b0; v4 = 1'b0;

    // Hand-computed directed vectors, back-to-back.
    send4(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    send4(4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0);
    send4(4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b1);
    send4(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    send4(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
    send4(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
    send4(4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    v4 = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      check("hold_sum", 64'(s4), 64'h3);
      check("hold_out_valid", 64'(ovld4), 64'h0);
    end

    @(negedge clk);
    rst = 1'b1; v4 = 1'b1; a4 = 4'b0010; b4 = 4'b0010; c4 = 1'b0;
    @(posedge clk); #1;
    check("rst_win_sum", 64'(s4), 64'h0);
    check("rst_win_cout", 64'(co4), 64'h0);
    check("rst_win_out_valid", 64'(ovld4), 64'h0);
    @(negedge clk);
    rst = 1'b0; v4 = 1'b0;

    for (int i = 0; i < 512; i++) begin
      ea = i[3:0]; eb = i[7:4]; ec = i[8];
      t4 = {1'b0, ea} + {1'b0, eb} + {4'h0, ec};
      send4(ea, eb, ec, t4[3:0], t4[4], (ea[3] == eb[3]) && (t4[3] != ea[3]));
    end
    @(negedge clk);
    v4 = 1'b0;

    send16(16'hFFFF, 16'hFFFF, 1'b1);
    send16(16'h7FFF, 16'h0001, 1'b0);
    send16(16'h8000, 16'h8000, 1'b0);
    send16(16'hFFFF, 16'h0000, 1'b1);
    for (int i = 0; i < 300; i++)
      send16(16'($urandom), 16'($urandom), 1'($urandom));
    @(negedge clk);
    v16 = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check("w4_queue_drained", 64'(q4.size()), 64'h0);
    check("w16_queue_drained", 64'(q16.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
